// File: rtl/zaxxon_snd_pkg.sv
// zaxxon_snd_pkg: shared types and widths for the sound-sample SDRAM arbiter
package zaxxon_snd_pkg;
    localparam int WAVE_AW = 20;
    localparam int MEM_AW  = 25;
    localparam int WAVE_DW = 16;
    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, GAP} arb_state_t;
endpackage

// File: rtl/sdram_wave_arbiter_if.sv
// sdram_wave_arbiter_if: download, sample-channel and SDRAM-side signals of the arbiter
interface sdram_wave_arbiter_if
    import zaxxon_snd_pkg::*;
#(
    parameter int NCH = 4
);
    logic                   dl_active;
    logic                   dl_wr;
    logic [MEM_AW-1:0]      dl_addr;
    logic [7:0]             dl_data;
    logic [NCH-1:0]         ch_req;
    logic [NCH*WAVE_AW-1:0] ch_addr;
    logic [NCH-1:0]         ch_ack;
    logic [WAVE_DW-1:0]     rd_data;
    logic [MEM_AW-1:0]      mem_addr;
    logic                   mem_rd;
    logic                   mem_we;
    logic [7:0]             mem_din;
    logic [WAVE_DW-1:0]     mem_dout;
    logic                   dl_overflow;
    modport master (
        input  dl_active, dl_wr, dl_addr, dl_data, ch_req, ch_addr, mem_dout,
        output ch_ack, rd_data, mem_addr, mem_rd, mem_we, mem_din, dl_overflow
    );
    modport slave (
        output dl_active, dl_wr, dl_addr, dl_data, ch_req, ch_addr, mem_dout,
        input  ch_ack, rd_data, mem_addr, mem_rd, mem_we, mem_din, dl_overflow
    );
endinterface

// File: rtl/wave_rr_pick.sv
// wave_rr_pick: lowest-indexed requester at or after the pointer, wrapping
module wave_rr_pick #(
    parameter int NCH = 4,
    parameter int PW  = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [PW-1:0]  gnt_o,
    output logic           any_o
);
    logic [PW-1:0] idx;
    // scan from the farthest slot back to the pointer so the nearest requester wins
    always_comb begin
        gnt_o = ptr_i;
        idx   = ptr_i;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_i) + k) % NCH);
            if (req_i[idx]) gnt_o = idx;
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/sdram_wave_arbiter.sv
// sdram_wave_arbiter: shares the SDRAM port between download writes and round-robin sample reads
module sdram_wave_arbiter
    import zaxxon_snd_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int RD_LAT  = 6,
    parameter int CMD_GAP = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    sdram_wave_arbiter_if.master bus
);
    localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
    arb_state_t         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, pick;
    logic               any, done, drain;
    logic               wpend_q, wpend_d, ovf_q, ovf_d;
    logic [MEM_AW-1:0]  waddr_q, waddr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [WAVE_AW-1:0] raddr_q, raddr_d;
    logic [WAVE_DW-1:0] rd_q, rd_d;

    wave_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
        .req_i(bus.ch_req),
        .ptr_i(ptr_q),
        .gnt_o(pick),
        .any_o(any)
    );

    assign done  = state_q == WAIT && cnt_q == 8'd0;
    assign drain = state_q == WRITE;

    // next state: write buffer, FSM, counters, round-robin pointer and read capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        raddr_d = raddr_q;
        rd_d    = rd_q;
        wpend_d = drain ? 1'b0 : wpend_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        if (bus.dl_wr) begin
            if (wpend_q && !drain) ovf_d = 1'b1;
            else begin
                wpend_d = 1'b1;
                waddr_d = bus.dl_addr;
                wdata_d = bus.dl_data;
            end
        end
        case (state_q)
            IDLE: begin
                // a strobe seen this cycle is already latched, so it can issue next cycle
                if (wpend_q || bus.dl_wr) state_d = WRITE;
                else if (!bus.dl_active && any) begin
                    state_d = READ;
                    gnt_d   = pick;
                    raddr_d = bus.ch_addr[pick*WAVE_AW +: WAVE_AW];
                end
            end
            WRITE: begin
                state_d = CMD_GAP > 1 ? GAP : IDLE;
                cnt_d   = 8'(CMD_GAP - 2);
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = 8'(RD_LAT - 1);
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (done) begin
                    rd_d    = bus.mem_dout;
                    ptr_d   = gnt_q == PW'(NCH - 1) ? '0 : gnt_q + 1'b1;
                    state_d = CMD_GAP > 1 ? GAP : IDLE;
                    cnt_d   = 8'(CMD_GAP - 2);
                end
            end
            GAP: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = cnt_q == 8'd0 ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any read in flight without an ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            raddr_q <= '0;
            rd_q    <= '0;
            wpend_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            raddr_q <= raddr_d;
            rd_q    <= rd_d;
            wpend_q <= wpend_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    // read data bypasses the capture register on the ack cycle so it is valid with the ack
    assign bus.ch_ack      = done ? NCH'(1) << gnt_q : '0;
    assign bus.rd_data     = done ? bus.mem_dout : rd_q;
    assign bus.mem_rd      = state_q == READ;
    assign bus.mem_we      = drain;
    assign bus.mem_addr    = drain ? waddr_q : state_q == READ ? MEM_AW'(raddr_q) : '0;
    assign bus.mem_din     = drain ? wdata_q : '0;
    assign bus.dl_overflow = ovf_q;
endmodule

// File: tb/tb_sdram_wave_arbiter.sv
// tb_sdram_wave_arbiter: directed vectors and corner sequences for the SDRAM wave arbiter
module tb_sdram_wave_arbiter;
    import zaxxon_snd_pkg::*;
    localparam int NCH = 4, RD_LAT = 6, CMD_GAP = 2;

    typedef struct {
        int          ch;
        logic [19:0] addr;
        logic [15:0] data;
        logic [3:0]  ack;
    } rd_vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_wave_arbiter_if #(.NCH(NCH)) bus ();
    sdram_wave_arbiter #(.NCH(NCH), .RD_LAT(RD_LAT), .CMD_GAP(CMD_GAP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_pass = 0, n_chk = 0;
    int mdly = 0;
    logic [19:0] maddr = '0;

    function automatic logic [15:0] mem_val(input logic [19:0] a);
        return a == 20'h12345 ? 16'hBEEF : a[15:0] ^ 16'h5A5A;
    endfunction

    // SDRAM model: data becomes valid RD_LAT clocks after the read strobe and stays until the next read
    always @(negedge clk) begin
        if (!reset_n && mdly == 0) bus.mem_dout = '0;
        if (bus.mem_rd) begin
            maddr = bus.mem_addr[19:0];
            mdly = RD_LAT - 1;
            bus.mem_dout = 16'hDEAD;
        end else if (mdly > 0) begin
            mdly--;
            if (mdly == 0) bus.mem_dout = mem_val(maddr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ch_ack == '0 && n < 40);
        chk("ack_seen", 32'(bus.ch_ack != '0), 32'd1);
    endtask

    rd_vec_t vec[4];
    int n, acks, ack_c, we_c, rd_n, we_n;
    logic [24:0] we_a;
    logic [7:0] we_d;

    initial begin
        vec[0] = '{2, 20'h12345, 16'hBEEF, 4'b0100};
        vec[1] = '{0, 20'h00000, 16'h5A5A, 4'b0001};
        vec[2] = '{3, 20'hFFFFF, 16'hA5A5, 4'b1000};
        vec[3] = '{1, 20'h0ABCD, 16'hF197, 4'b0010};
        bus.dl_active = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.ch_req = '0; bus.ch_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus.ch_ack), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_din", 32'(bus.mem_din), 0);
        chk("rst_overflow", 32'(bus.dl_overflow), 0);
        reset_n = 1;
        @(negedge clk);

        foreach (vec[i]) begin
            bus.ch_addr[vec[i].ch*20 +: 20] = vec[i].addr;
            bus.ch_req[vec[i].ch] = 1'b1;
            @(negedge clk);
            chk("rd_strobe", 32'(bus.mem_rd), 1);
            chk("rd_addr", 32'(bus.mem_addr), 32'(vec[i].addr));
            wait_ack(n);
            chk("rd_latency", 32'(n), RD_LAT);
            chk("ack_onehot", 32'(bus.ch_ack), 32'(vec[i].ack));
            chk("rd_data", 32'(bus.rd_data), 32'(vec[i].data));
            bus.ch_req = '0;
            @(negedge clk);
            chk("ack_pulse", 32'(bus.ch_ack), 0);
            chk("rd_hold", 32'(bus.rd_data), 32'(vec[i].data));
            @(negedge clk);
        end

        // reset in the middle of a read's wait: no ack, outputs cleared, pointer back to 0
        bus.ch_addr[1*20 +: 20] = 20'h00077;
        bus.ch_req = 4'b0010;
        repeat (4) @(negedge clk);
        reset_n = 0;
        #1;
        chk("mid_rst_ack", 32'(bus.ch_ack), 0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
        chk("mid_rst_mem_rd", 32'(bus.mem_rd), 0);
        bus.ch_req = '0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ch_ack != '0) acks++;
        end
        chk("mid_rst_no_ack", 32'(acks), 0);
        reset_n = 1;
        bus.ch_addr[0*20 +: 20] = 20'h00010;
        bus.ch_addr[3*20 +: 20] = 20'h00030;
        bus.ch_req = 4'b1001;
        @(negedge clk);
        chk("ptr_reset_addr", 32'(bus.mem_addr), 32'h10);
        wait_ack(n);
        chk("ptr_reset_ack", 32'(bus.ch_ack), 32'b0001);
        chk("ptr_reset_data", 32'(bus.rd_data), 32'h5A4A);
        bus.ch_req[0] = 1'b0;
        wait_ack(n);
        chk("next_ack", 32'(bus.ch_ack), 32'b1000);
        chk("next_data", 32'(bus.rd_data), 32'h5A6A);
        chk("next_spacing", 32'(n), 9);

        // all four channels requesting continuously
        bus.ch_addr[1*20 +: 20] = 20'h00020;
        bus.ch_addr[2*20 +: 20] = 20'h00040;
        bus.ch_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack(n);
            chk("rr_order", 32'(bus.ch_ack), 32'(4'b0001 << (j % 4)));
            chk("rr_spacing", 32'(n), 9);
        end
        bus.ch_req = '0;
        repeat (2) @(negedge clk);

        // download starts while ch1 is waiting for data
        bus.ch_req = 4'b0010;
        @(negedge clk);
        chk("dl_rd_addr", 32'(bus.mem_addr), 32'h20);
        repeat (2) @(negedge clk);
        bus.dl_active = 1; bus.dl_wr = 1; bus.dl_addr = 25'h000100; bus.dl_data = 8'hA5;
        bus.ch_req[2] = 1'b1;
        @(negedge clk);
        bus.dl_wr = 0;
        ack_c = -1; we_c = -1; rd_n = 0; we_a = '0; we_d = '0;
        for (int c = 0; c < 20; c++) begin
            if (bus.ch_ack[1] && ack_c < 0) begin
                ack_c = c;
                bus.ch_req[1] = 1'b0;
            end
            if (bus.mem_we && we_c < 0) begin
                we_c = c; we_a = bus.mem_addr; we_d = bus.mem_din;
            end
            if (bus.mem_rd) rd_n++;
            @(negedge clk);
        end
        chk("dl_ack_cycle", 32'(ack_c), 3);
        chk("dl_we_cycle", 32'(we_c), 6);
        chk("dl_we_addr", 32'(we_a), 32'h100);
        chk("dl_we_data", 32'(we_d), 32'hA5);
        chk("dl_no_read", 32'(rd_n), 0);
        chk("dl_no_overflow", 32'(bus.dl_overflow), 0);
        bus.dl_active = 0;
        @(negedge clk);
        chk("resume_rd", 32'(bus.mem_rd), 1);
        chk("resume_addr", 32'(bus.mem_addr), 32'h40);
        wait_ack(n);
        chk("resume_ack", 32'(bus.ch_ack), 32'b0100);
        chk("resume_data", 32'(bus.rd_data), 32'h5A1A);
        bus.ch_req = '0;
        repeat (2) @(negedge clk);

        // second strobe while the first is still buffered is dropped
        bus.ch_addr[3*20 +: 20] = 20'h00050;
        bus.ch_req = 4'b1000;
        repeat (2) @(negedge clk);
        bus.dl_wr = 1; bus.dl_addr = 25'h200; bus.dl_data = 8'h11;
        @(negedge clk);
        bus.dl_wr = 0;
        @(negedge clk);
        bus.dl_wr = 1; bus.dl_addr = 25'h201; bus.dl_data = 8'h22;
        @(negedge clk);
        bus.dl_wr = 0;
        chk("ovf_set", 32'(bus.dl_overflow), 1);
        we_n = 0; acks = 0; we_a = '0; we_d = '0;
        for (int c = 0; c < 20; c++) begin
            if (bus.ch_ack[3]) begin
                acks++;
                bus.ch_req = '0;
            end
            if (bus.mem_we) begin
                if (we_n == 0) begin
                    we_a = bus.mem_addr; we_d = bus.mem_din;
                end
                we_n++;
            end
            @(negedge clk);
        end
        chk("ovf_ack", 32'(acks), 1);
        chk("ovf_we_count", 32'(we_n), 1);
        chk("ovf_we_addr", 32'(we_a), 32'h200);
        chk("ovf_we_data", 32'(we_d), 32'h11);
        chk("ovf_sticky", 32'(bus.dl_overflow), 1);
        reset_n = 0;
        repeat (2) @(negedge clk);
        chk("ovf_cleared", 32'(bus.dl_overflow), 0);
        reset_n = 1;
        @(negedge clk);

        // write strobes every 3 clocks with CMD_GAP = 2
        bus.dl_active = 1;
        for (int i = 0; i < 6; i++) begin
            bus.dl_wr = 1; bus.dl_addr = 25'(32'h300 + i); bus.dl_data = 8'(8'h30 + i);
            @(negedge clk);
            bus.dl_wr = 0;
            chk("b2b_we", 32'(bus.mem_we), 1);
            chk("b2b_addr", 32'(bus.mem_addr), 32'h300 + i);
            chk("b2b_data", 32'(bus.mem_din), 32'h30 + i);
            repeat (2) @(negedge clk);
        end
        chk("b2b_no_overflow", 32'(bus.dl_overflow), 0);

        // strobe in the same cycle the buffer drains is accepted
        bus.dl_wr = 1; bus.dl_addr = 25'h400; bus.dl_data = 8'h44;
        @(negedge clk);
        chk("drain_we1", 32'(bus.mem_we), 1);
        chk("drain_addr1", 32'(bus.mem_addr), 32'h400);
        bus.dl_addr = 25'h401; bus.dl_data = 8'h55;
        @(negedge clk);
        bus.dl_wr = 0;
        repeat (2) @(negedge clk);
        chk("drain_we2", 32'(bus.mem_we), 1);
        chk("drain_addr2", 32'(bus.mem_addr), 32'h401);
        chk("drain_data2", 32'(bus.mem_din), 32'h55);
        chk("drain_no_overflow", 32'(bus.dl_overflow), 0);
        bus.dl_active = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
